// File: rtl/param_stack_pkg.sv
// Shared encodings for the parametrised data stack and its ALU:
// stack-op bit positions, ALU opcodes and compare status codes.
package param_stack_pkg;

    localparam int SOP_POP   = 3;
    localparam int SOP_PUSH  = 2;
    localparam int SOP_WRITE = 1;
    localparam int SOP_READ  = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_MUL = 3'b011,
        ALU_CMP = 3'b100,
        ALU_OR  = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EQ = 2'b00,
        ST_LT = 2'b01,
        ST_GT = 2'b10
    } status_e;

endpackage

// File: rtl/param_stack_dp_alu.sv
// Combinational ALU for the stack datapath: a is NOS, b is TOS.
// Multiply (aluop 011) exists only when STACK_ALU_MUL_EN is defined.
module stack_alu
    import param_stack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       status,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (aluop)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_CMP: result = '0;
`ifdef STACK_ALU_MUL_EN
            ALU_MUL: result = a * b;
`endif
            default: illegal = 1'b1;
        endcase
    end

    // Unsigned ordering of NOS against TOS.
    always_comb begin
        if (a == b) begin
            status = ST_EQ;
        end else if (a < b) begin
            status = ST_LT;
        end else begin
            status = ST_GT;
        end
    end

endmodule

// File: rtl/param_stack_dp.sv
// DEPTH x WIDTH LIFO stack with ALU on TOS/NOS, registered read port and sticky errors.
// Optional macro STACK_ALU_MUL_EN enables aluop 011 (low-WIDTH unsigned multiply).
module param_stack_dp
    import param_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [3:0]       sop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             alu_en,
    input  logic [2:0]       aluop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic [1:0]       status,
    output logic             ovf,
    output logic             unf,
    output logic             cmd_err
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [1:0]       status_q, status_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             cmd_err_q, cmd_err_d;

    logic [AW-1:0]    tos_idx, nos_idx, push_idx;
    logic             has_one, has_two, is_full;
    logic [WIDTH-1:0] tos_w, nos_w;
    logic [WIDTH-1:0] alu_result;
    logic [1:0]       alu_status;
    logic             alu_illegal;

    // Entries live at index 0..count-1, so TOS is always at count-1.
    assign tos_idx  = AW'(count_q - CW'(1));
    assign nos_idx  = AW'(count_q - CW'(2));
    assign push_idx = AW'(count_q);
    assign has_one  = (count_q != '0);
    assign has_two  = (count_q >= CW'(2));
    assign is_full  = (count_q == CW'(DEPTH));
    assign tos_w    = has_one ? stack_q[tos_idx] : '0;
    assign nos_w    = has_two ? stack_q[nos_idx] : '0;

    stack_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a       (nos_w),
        .b       (tos_w),
        .aluop   (aluop),
        .result  (alu_result),
        .status  (alu_status),
        .illegal (alu_illegal)
    );

    always_comb begin
        stack_d    = stack_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        status_d   = status_q;
        ovf_d      = ovf_q & ~err_clr;
        unf_d      = unf_q & ~err_clr;
        cmd_err_d  = cmd_err_q & ~err_clr;

        if (alu_en) begin
            if ((sop != 4'b0000) || alu_illegal) begin
                cmd_err_d = 1'b1;
            end else if (!has_two) begin
                unf_d = 1'b1;
            end else if (aluop == ALU_CMP) begin
                status_d = alu_status;
            end else begin
                stack_d[nos_idx] = alu_result;
                count_d          = count_q - CW'(1);
            end
        end else if (sop[SOP_WRITE] && (sop[SOP_PUSH] || sop[SOP_POP])) begin
            cmd_err_d = 1'b1;
        end else begin
            // Read samples the pre-update TOS, so it composes with any stack op.
            if (sop[SOP_READ]) begin
                rd_data_d  = tos_w;
                rd_valid_d = 1'b1;
                if (!has_one) begin
                    unf_d = 1'b1;
                end
            end
            if (sop[SOP_PUSH] && sop[SOP_POP]) begin
                if (has_one) begin
                    stack_d[tos_idx] = push_data;
                end else begin
                    stack_d[0] = push_data;
                    count_d    = CW'(1);
                end
            end else if (sop[SOP_PUSH]) begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    stack_d[push_idx] = push_data;
                    count_d           = count_q + CW'(1);
                end
            end else if (sop[SOP_POP]) begin
                if (!has_one) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end else if (sop[SOP_WRITE]) begin
                if (!has_one) begin
                    unf_d = 1'b1;
                end else begin
                    stack_d[tos_idx] = push_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            status_q   <= ST_EQ;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            stack_q    <= stack_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            status_q   <= status_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign tos      = tos_w;
    assign nos      = nos_w;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign full     = is_full;
    assign empty    = ~has_one;
    assign status   = status_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_param_stack_dp.sv
// Directed self-checking bench for param_stack_dp (WIDTH=16, DEPTH=8).
// Honours STACK_ALU_MUL_EN when deciding what aluop 011 should do.
module tb_param_stack_dp;

    logic        clk;
    logic        async_reset;
    logic [3:0]  sop;
    logic [15:0] push_data;
    logic        alu_en;
    logic [2:0]  aluop;
    logic        err_clr;
    logic [15:0] tos, nos, rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic        full, empty;
    logic [1:0]  status;
    logic        ovf, unf, cmd_err;

    int errors = 0;
    int checks = 0;

    param_stack_dp #(
        .WIDTH (16),
        .DEPTH (8)
    ) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .sop         (sop),
        .push_data   (push_data),
        .alu_en      (alu_en),
        .aluop       (aluop),
        .err_clr     (err_clr),
        .tos         (tos),
        .nos         (nos),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .status      (status),
        .ovf         (ovf),
        .unf         (unf),
        .cmd_err     (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one command for one rising edge, then return the inputs to idle.
    task automatic applyStimulus(input logic [3:0] s, input logic [15:0] d,
                                 input logic ae, input logic [2:0] op, input logic ec);
        sop       = s;
        push_data = d;
        alu_en    = ae;
        aluop     = op;
        err_clr   = ec;
        @(posedge clk);
        #1;
        sop       = 4'b0000;
        push_data = 16'h0000;
        alu_en    = 1'b0;
        aluop     = 3'b000;
        err_clr   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushVal(input logic [15:0] d);
        applyStimulus(4'b0100, d, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic aluOp(input logic [2:0] op);
        applyStimulus(4'b0000, 16'h0000, 1'b1, op, 1'b0);
    endtask

    task automatic resetDut();
        async_reset = 1'b1;
        @(posedge clk);
        #1;
        async_reset = 1'b0;
    endtask

    initial begin
        async_reset = 1'b1;
        sop         = 4'b0000;
        push_data   = 16'h0000;
        alu_en      = 1'b0;
        aluop       = 3'b000;
        err_clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_tos", 32'(tos), 32'd0);
        checkOutput("rst_rdvalid", 32'(rd_valid), 32'd0);
        checkOutput("rst_flags", 32'({status, ovf, unf, cmd_err}), 32'd0);
        async_reset = 1'b0;

        // Add
        pushVal(16'd5);
        pushVal(16'd5);
        checkOutput("push2_count", 32'(count), 32'd2);
        checkOutput("push2_tos", 32'(tos), 32'd5);
        checkOutput("push2_nos", 32'(nos), 32'd5);
        aluOp(3'b000);
        checkOutput("add_count", 32'(count), 32'd1);
        checkOutput("add_tos", 32'(tos), 32'd10);

        // Subtract with wrap: 3 - 9
        pushVal(16'd3);
        pushVal(16'd9);
        aluOp(3'b001);
        checkOutput("sub_tos", 32'(tos), 32'hFFFA);
        checkOutput("sub_nos", 32'(nos), 32'd10);
        checkOutput("sub_count", 32'(count), 32'd2);

        // Compare equal, then NOS > TOS
        pushVal(16'd7);
        pushVal(16'd7);
        aluOp(3'b100);
        checkOutput("cmp_eq_status", 32'(status), 32'b00);
        checkOutput("cmp_eq_count", 32'(count), 32'd4);
        pushVal(16'd2);
        aluOp(3'b100);
        checkOutput("cmp_gt_status", 32'(status), 32'b10);
        checkOutput("cmp_gt_tos", 32'(tos), 32'd2);
        pushVal(16'd20);
        aluOp(3'b100);
        checkOutput("cmp_lt_status", 32'(status), 32'b01);
        aluOp(3'b010);
        checkOutput("and_tos", 32'(tos), 32'd0);
        pushVal(16'h00F0);
        aluOp(3'b110);
        checkOutput("or_tos", 32'(tos), 32'h00F0);
        checkOutput("status_hold", 32'(status), 32'b01);

        // Fill to DEPTH, overflow, clear
        resetDut();
        for (int i = 1; i <= 8; i++) begin
            pushVal(16'(i));
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd8);
        pushVal(16'd9);
        checkOutput("ovf_flag", 32'(ovf), 32'd1);
        checkOutput("ovf_tos", 32'(tos), 32'd8);
        checkOutput("ovf_count", 32'(count), 32'd8);
        applyStimulus(4'b0000, 16'h0000, 1'b0, 3'b000, 1'b1);
        checkOutput("ovf_clr", 32'(ovf), 32'd0);

        // Underflow and illegal commands
        resetDut();
        applyStimulus(4'b1000, 16'h0000, 1'b0, 3'b000, 1'b0);
        checkOutput("pop_empty_unf", 32'(unf), 32'd1);
        checkOutput("pop_empty_count", 32'(count), 32'd0);
        applyStimulus(4'b0000, 16'h0000, 1'b0, 3'b000, 1'b1);
        pushVal(16'd1);
        aluOp(3'b000);
        checkOutput("add_one_unf", 32'(unf), 32'd1);
        checkOutput("add_one_count", 32'(count), 32'd1);
        checkOutput("add_one_tos", 32'(tos), 32'd1);
        applyStimulus(4'b0100, 16'd5, 1'b1, 3'b000, 1'b0);
        checkOutput("alu_sop_cmderr", 32'(cmd_err), 32'd1);
        checkOutput("alu_sop_count", 32'(count), 32'd1);
        applyStimulus(4'b0110, 16'd5, 1'b0, 3'b000, 1'b1);
        checkOutput("wr_push_cmderr", 32'(cmd_err), 32'd1);
        checkOutput("wr_push_count", 32'(count), 32'd1);
        applyStimulus(4'b0000, 16'h0000, 1'b0, 3'b000, 1'b1);
        checkOutput("clr_all", 32'({ovf, unf, cmd_err}), 32'd0);

        // Pop-and-read, then write
        resetDut();
        pushVal(16'd4);
        applyStimulus(4'b1001, 16'h0000, 1'b0, 3'b000, 1'b0);
        checkOutput("read_data", 32'(rd_data), 32'd4);
        checkOutput("read_valid", 32'(rd_valid), 32'd1);
        checkOutput("read_count", 32'(count), 32'd0);
        applyStimulus(4'b0000, 16'h0000, 1'b0, 3'b000, 1'b0);
        checkOutput("read_pulse_end", 32'(rd_valid), 32'd0);
        pushVal(16'd6);
        applyStimulus(4'b0010, 16'd11, 1'b0, 3'b000, 1'b0);
        checkOutput("write_tos", 32'(tos), 32'd11);
        checkOutput("write_count", 32'(count), 32'd1);
        applyStimulus(4'b1100, 16'd12, 1'b0, 3'b000, 1'b0);
        checkOutput("pushpop_tos", 32'(tos), 32'd12);
        checkOutput("pushpop_count", 32'(count), 32'd1);

        // Pop to empty, then pop with err_clr: the new error wins
        applyStimulus(4'b1000, 16'h0000, 1'b0, 3'b000, 1'b0);
        applyStimulus(4'b1000, 16'h0000, 1'b0, 3'b000, 1'b1);
        checkOutput("set_wins_unf", 32'(unf), 32'd1);
        applyStimulus(4'b0001, 16'h0000, 1'b0, 3'b000, 1'b0);
        checkOutput("read_empty_data", 32'(rd_data), 32'd0);
        checkOutput("read_empty_valid", 32'(rd_valid), 32'd1);
        applyStimulus(4'b1100, 16'd33, 1'b0, 3'b000, 1'b1);
        checkOutput("pushpop_empty_count", 32'(count), 32'd1);
        checkOutput("pushpop_empty_unf", 32'(unf), 32'd0);

        // Multiply opcode
        resetDut();
        pushVal(16'd300);
        pushVal(16'd300);
        aluOp(3'b011);
`ifdef STACK_ALU_MUL_EN
        checkOutput("mul_tos", 32'(tos), 32'h5F90);
        checkOutput("mul_count", 32'(count), 32'd1);
`else
        checkOutput("mul_cmderr", 32'(cmd_err), 32'd1);
        checkOutput("mul_count", 32'(count), 32'd2);
`endif
        aluOp(3'b101);
        checkOutput("op101_cmderr", 32'(cmd_err), 32'd1);

        // Asynchronous reset between edges, while a push is being presented
        sop       = 4'b0100;
        push_data = 16'd77;
        #2;
        async_reset = 1'b1;
        #1;
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_tos", 32'(tos), 32'd0);
        checkOutput("arst_flags", 32'({full, ovf, unf, cmd_err, rd_valid, status}), 32'd0);
        checkOutput("arst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("arst_hold_count", 32'(count), 32'd0);
        async_reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_push_count", 32'(count), 32'd1);
        checkOutput("post_rst_push_tos", 32'(tos), 32'd77);
        sop       = 4'b0000;
        push_data = 16'h0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
